mem_stage_ctrl: RTL and testbench

- Memory-access stage controller between the execute stage and the data memory.
- Accepts one load/store/push/pop request at a time over a valid/ready handshake and owns the stack pointer register.
- Drives the data memory's registered interface: MemAddr, MemRD, MemWR, StackOP, stack_pointer, MemDataIn.
- Waits out the memory's one-cycle registered read latency and returns the result over a valid/ready response channel.

---
 rtl/mem_stage_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//
// Memory-access stage controller between the execute stage and a data memory
// with a registered (one-cycle read latency) interface. It accepts one
// LOAD/STORE/PUSH/POP request at a time over a valid/ready handshake, owns the
// stack pointer, drives the memory strobes for exactly one cycle, waits out the
// read latency, and returns the result over a valid/ready response channel.
//
// Optional feature macro: MEM_STAGE_BOUNDS_CHECK_EN
//   defined   : LOAD/STORE into the stack region, PUSH when full and POP when
//               empty are rejected with resp_error=1 and no memory access.
//   undefined : no checks, every request accesses memory, resp_error stays 0,
//               and the stack pointer wraps modulo 2^SP_W.
//
// Parameters:
//   MEM_DEPTH  : data memory depth in 32-bit words
//   STACK_BASE : first stack word; words below it form the normal region
//   SP_W       : width of the stack pointer
//
// Ports:
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake
//   req_op                  : 0=LOAD 1=STORE 2=PUSH 3=POP
//   req_addr, req_wdata     : word address (LOAD/STORE), write data
//   resp_valid/resp_ready   : response handshake
//   resp_rdata, resp_error  : load/pop data (0 otherwise), rejection flag
//   MemAddr, MemRD, MemWR   : memory address and strobes
//   StackOP, stack_pointer  : stack access select and current SP
//   MemDataIn, MemDataOut   : memory write data, memory read data
//   sp_empty, sp_full       : SP==STACK_BASE, SP==MEM_DEPTH-1
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int MEM_DEPTH  = 16,
  parameter int STACK_BASE = MEM_DEPTH / 2,
  parameter int SP_W       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_rdata,
  output logic            resp_error,
  output logic [31:0]     MemAddr,
  output logic            MemRD,
  output logic            MemWR,
  output logic            StackOP,
  output logic [SP_W-1:0] stack_pointer,
  output logic [31:0]     MemDataIn,
  input  logic [31:0]     MemDataOut,
  output logic            sp_empty,
  output logic            sp_full
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_PUSH  = 2'd2,
    OP_POP   = 2'd3
  } op_t;

  localparam logic [SP_W-1:0] SP_BASE    = SP_W'(STACK_BASE);
  localparam logic [SP_W-1:0] SP_TOP     = SP_W'(MEM_DEPTH - 1);
  localparam logic [SP_W-1:0] SP_ONE     = SP_W'(1);
  localparam logic [31:0]     STACK_ADDR = 32'(STACK_BASE);

  state_t          state;
  op_t             op;
  op_t             req_kind;
  logic            accept;
  logic            req_err;
  logic [SP_W-1:0] sp_next;

  // A request is only ever taken in IDLE, where req_ready is already high.
  assign req_kind = op_t'(req_op);
  assign accept   = (state == IDLE) && req_valid && req_ready;

  // Decide whether the incoming request must be rejected. Normal accesses may
  // not reach into the stack region, and the stack may neither overflow into
  // the reserved top slot nor underflow below its base. Without the bounds
  // feature every request is allowed through.
  always_comb begin
    req_err = 1'b0;
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    case (req_kind)
      OP_LOAD,
      OP_STORE: req_err = (req_addr >= STACK_ADDR);
      OP_PUSH:  req_err = sp_full;
      OP_POP:   req_err = sp_empty;
      default:  req_err = 1'b0;
    endcase
`endif
  end

  // Next stack pointer. POP pre-decrements on the accepting edge so the
  // memory sees the slot being popped during ACCESS; PUSH writes the current
  // free slot during ACCESS and only then post-increments on the exiting edge.
  // Arithmetic is plain SP_W-bit, so it wraps naturally when unchecked.
  always_comb begin
    sp_next = stack_pointer;
    if (accept && !req_err && (req_kind == OP_POP)) begin
      sp_next = stack_pointer - SP_ONE;
    end else if ((state == ACCESS) && (op == OP_PUSH)) begin
      sp_next = stack_pointer + SP_ONE;
    end
  end

  // Main controller: one registered FSM that also owns the stack pointer, the
  // status flags and every output. The flags are derived from sp_next so they
  // always describe the SP value that is visible in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op            <= OP_LOAD;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_error    <= 1'b0;
      resp_rdata    <= '0;
      MemAddr       <= '0;
      MemDataIn     <= '0;
      MemRD         <= 1'b0;
      MemWR         <= 1'b0;
      StackOP       <= 1'b0;
      stack_pointer <= SP_BASE;
      sp_empty      <= 1'b1;
      sp_full       <= 1'b0;
    end else begin
      stack_pointer <= sp_next;
      sp_empty      <= (sp_next == SP_BASE);
      sp_full       <= (sp_next == SP_TOP);

      case (state)
        IDLE: begin
          if (accept) begin
            req_ready  <= 1'b0;
            op         <= req_kind;
            resp_rdata <= '0;
            resp_error <= req_err;
            if (req_err) begin
              // Rejected: skip the memory entirely and answer immediately.
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              state <= ACCESS;
              case (req_kind)
                OP_LOAD: begin
                  MemAddr <= req_addr;
                  MemRD   <= 1'b1;
                end
                OP_STORE: begin
                  MemAddr   <= req_addr;
                  MemDataIn <= req_wdata;
                  MemWR     <= 1'b1;
                end
                OP_PUSH: begin
                  StackOP   <= 1'b1;
                  MemWR     <= 1'b1;
                  MemDataIn <= req_wdata;
                end
                OP_POP: begin
                  StackOP <= 1'b1;
                  MemRD   <= 1'b1;
                end
                default: begin
                  MemRD <= 1'b0;
                end
              endcase
            end
          end
        end

        ACCESS: begin
          // Strobes live for exactly this one cycle.
          MemRD   <= 1'b0;
          MemWR   <= 1'b0;
          StackOP <= 1'b0;
          if ((op == OP_LOAD) || (op == OP_POP)) begin
            state <= CAPTURE;
          end else begin
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end

        CAPTURE: begin
          // Read data from the registered memory is valid in this cycle.
          resp_rdata <= MemDataOut;
          resp_valid <= 1'b1;
          state      <= RESP;
        end

        RESP: begin
          // Response fields hold until the consumer takes them; req_ready
          // only returns in IDLE, so no request overlaps a completing one.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
//
// Directed self-checking bench for mem_stage_ctrl at default parameters
// (MEM_DEPTH=16, STACK_BASE=8). A small registered memory model answers the
// controller's strobes. Expectations for rejected requests depend on whether
// MEM_STAGE_BOUNDS_CHECK_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] MemAddr;
  logic        MemRD;
  logic        MemWR;
  logic        StackOP;
  logic [31:0] stack_pointer;
  logic [31:0] MemDataIn;
  logic [31:0] MemDataOut;
  logic        sp_empty;
  logic        sp_full;

  int compared   = 0;
  int mismatched = 0;
  int wr_count   = 0;

  logic [31:0] mem [16];

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] STORE = 2'd1;
  localparam logic [1:0] PUSH  = 2'd2;
  localparam logic [1:0] POP   = 2'd3;

  mem_stage_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_error    (resp_error),
    .MemAddr       (MemAddr),
    .MemRD         (MemRD),
    .MemWR         (MemWR),
    .StackOP       (StackOP),
    .stack_pointer (stack_pointer),
    .MemDataIn     (MemDataIn),
    .MemDataOut    (MemDataOut),
    .sp_empty      (sp_empty),
    .sp_full       (sp_full)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Registered data memory model: writes and reads happen on the edge that
  // closes the strobe cycle, so read data appears one cycle after MemRD.
  always @(posedge clk) begin
    automatic logic [31:0] a = StackOP ? stack_pointer : MemAddr;
    if (MemWR) begin
      mem[a[3:0]] <= MemDataIn;
      wr_count    <= wr_count + 1;
    end
    if (MemRD) begin
      MemDataOut <= mem[a[3:0]];
    end
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request and let it be accepted on the next edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    checkOutput("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    checkOutput("req_ready_after_accept", {31'd0, req_ready}, 32'd0);
  endtask

  // Wait for the response (latency counted from the accepting edge as 1),
  // check it, and complete the handshake with resp_ready high.
  task automatic finishResp(input string tag, input logic [31:0] exp_rdata,
                            input logic exp_err, input int exp_lat);
    int lat = 1;
    while (resp_valid !== 1'b1 && lat < 16) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_rdata"}, resp_rdata, exp_rdata);
    checkOutput({tag, "_error"}, {31'd0, resp_error}, {31'd0, exp_err});
    tick();
    checkOutput({tag, "_valid_cleared"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int          wr_before;
    logic [31:0] held;
    int          guard;

    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    MemDataOut = 32'd0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = LOAD;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    doReset();

    // Reset state.
    checkOutput("rst_sp", stack_pointer, 32'd8);
    checkOutput("rst_sp_empty", {31'd0, sp_empty}, 32'd1);
    checkOutput("rst_sp_full", {31'd0, sp_full}, 32'd0);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_strobes", {29'd0, MemRD, MemWR, StackOP}, 32'd0);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_mem_addr", MemAddr, 32'd0);

    // STORE then LOAD through the normal region.
    wr_before = wr_count;
    applyStimulus(STORE, 32'd4, 32'h12345678);
    checkOutput("store_memwr", {31'd0, MemWR}, 32'd1);
    checkOutput("store_addr", MemAddr, 32'd4);
    checkOutput("store_wdata", MemDataIn, 32'h12345678);
    checkOutput("store_memrd", {31'd0, MemRD}, 32'd0);
    finishResp("store", 32'd0, 1'b0, 2);
    checkOutput("store_one_pulse", 32'(wr_count - wr_before), 32'd1);

    applyStimulus(LOAD, 32'd4, 32'd0);
    checkOutput("load_memrd", {31'd0, MemRD}, 32'd1);
    checkOutput("load_addr", MemAddr, 32'd4);
    finishResp("load", 32'h12345678, 1'b0, 3);
    checkOutput("load_req_ready_back", {31'd0, req_ready}, 32'd1);

    // PUSH then POP.
    applyStimulus(PUSH, 32'd0, 32'h87654321);
    checkOutput("push_strobes", {29'd0, MemRD, MemWR, StackOP}, 32'b011);
    checkOutput("push_sp_access", stack_pointer, 32'd8);
    finishResp("push", 32'd0, 1'b0, 2);
    checkOutput("push_sp_after", stack_pointer, 32'd9);
    checkOutput("push_sp_empty", {31'd0, sp_empty}, 32'd0);

    applyStimulus(POP, 32'd0, 32'd0);
    checkOutput("pop_strobes", {29'd0, MemRD, MemWR, StackOP}, 32'b101);
    checkOutput("pop_sp_access", stack_pointer, 32'd8);
    finishResp("pop", 32'h87654321, 1'b0, 3);
    checkOutput("pop_sp_after", stack_pointer, 32'd8);
    checkOutput("pop_sp_empty", {31'd0, sp_empty}, 32'd1);

    // Fill the stack.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(PUSH, 32'd0, 32'h100 + 32'(i));
      finishResp("fill", 32'd0, 1'b0, 2);
    end
    checkOutput("full_sp", stack_pointer, 32'd15);
    checkOutput("full_flag", {31'd0, sp_full}, 32'd1);

    wr_before = wr_count;
    applyStimulus(PUSH, 32'd0, 32'hCAFE0008);
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    checkOutput("overflow_no_memwr", {31'd0, MemWR}, 32'd0);
    finishResp("overflow", 32'd0, 1'b1, 1);
    checkOutput("overflow_no_pulse", 32'(wr_count - wr_before), 32'd0);
    checkOutput("overflow_sp", stack_pointer, 32'd15);
    checkOutput("overflow_full", {31'd0, sp_full}, 32'd1);
    applyStimulus(POP, 32'd0, 32'd0);
    finishResp("pop_top", 32'h106, 1'b0, 3);
    checkOutput("pop_top_sp", stack_pointer, 32'd14);
`else
    checkOutput("push8_memwr", {31'd0, MemWR}, 32'd1);
    checkOutput("push8_sp_access", stack_pointer, 32'd15);
    finishResp("push8", 32'd0, 1'b0, 2);
    checkOutput("push8_pulse", 32'(wr_count - wr_before), 32'd1);
    checkOutput("push8_sp", stack_pointer, 32'd16);
    checkOutput("push8_full", {31'd0, sp_full}, 32'd0);
    applyStimulus(POP, 32'd0, 32'd0);
    finishResp("pop_top", 32'hCAFE0008, 1'b0, 3);
    checkOutput("pop_top_sp", stack_pointer, 32'd15);
`endif

    // Underflow and region violation.
    doReset();
    applyStimulus(POP, 32'd0, 32'd0);
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    checkOutput("underflow_no_memrd", {31'd0, MemRD}, 32'd0);
    finishResp("underflow", 32'd0, 1'b1, 1);
    checkOutput("underflow_sp", stack_pointer, 32'd8);
`else
    checkOutput("underflow_sp_access", stack_pointer, 32'd7);
    finishResp("underflow", 32'd0, 1'b0, 3);
    checkOutput("underflow_sp", stack_pointer, 32'd7);
    checkOutput("underflow_empty", {31'd0, sp_empty}, 32'd0);
`endif

    doReset();
    wr_before = wr_count;
    applyStimulus(STORE, 32'd9, 32'hDEADBEEF);
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    checkOutput("region_no_strobe", {29'd0, MemRD, MemWR, StackOP}, 32'd0);
    finishResp("region", 32'd0, 1'b1, 1);
    checkOutput("region_no_pulse", 32'(wr_count - wr_before), 32'd0);
`else
    checkOutput("region_memwr", {31'd0, MemWR}, 32'd1);
    finishResp("region", 32'd0, 1'b0, 2);
    checkOutput("region_pulse", 32'(wr_count - wr_before), 32'd1);
`endif

    // Back-pressure on the response channel.
    doReset();
    applyStimulus(STORE, 32'd2, 32'hA5A5A5A5);
    finishResp("hold_store", 32'd0, 1'b0, 2);
    resp_ready = 1'b0;
    applyStimulus(LOAD, 32'd2, 32'd0);
    guard = 0;
    while (resp_valid !== 1'b1 && guard < 16) begin
      tick();
      guard++;
    end
    checkOutput("hold_first_rdata", resp_rdata, 32'hA5A5A5A5);
    held      = resp_rdata;
    req_valid = 1'b1;
    req_op    = STORE;
    req_addr  = 32'd3;
    req_wdata = 32'h11111111;
    wr_before = wr_count;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("hold_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("hold_rdata", resp_rdata, held);
      checkOutput("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    checkOutput("hold_release_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("hold_release_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("hold_no_stray_write", 32'(wr_count - wr_before), 32'd0);

    // Reset in the middle of a PUSH access.
    applyStimulus(PUSH, 32'd0, 32'h55);
    finishResp("pre_reset_push", 32'd0, 1'b0, 2);
    applyStimulus(PUSH, 32'd0, 32'h66);
    checkOutput("midreset_in_access", {31'd0, StackOP}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midreset_strobes", {29'd0, MemRD, MemWR, StackOP}, 32'd0);
    checkOutput("midreset_idle", {31'd0, req_ready}, 32'd1);
    checkOutput("midreset_no_resp", {31'd0, resp_valid}, 32'd0);
    checkOutput("midreset_sp", stack_pointer, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
